// File: rtl/id_ex_skid_pkg.sv
// id_ex_skid_pkg: shared opcodes, field widths and decoded packet layout for the decode/execute boundary
package id_ex_skid_pkg;
  localparam int OP_W = 5;
  localparam int FN_W = 2;
  localparam int PKT_DATA_W = 16;
  localparam int PKT_REG_W = 3;
  localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OP_W-1:0] OP_ALU = 5'b01000;
  localparam logic [OP_W-1:0] OP_BEQ = 5'b10000;
  localparam logic [OP_W-1:0] OP_JMP = 5'b10100;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b11011;
  localparam logic [OP_W-1:0] OP_LW = 5'b11100;
  localparam logic [OP_W-1:0] OP_SW = 5'b11101;
  typedef struct packed {
    logic [OP_W-1:0] op_code;
    logic [FN_W-1:0] funct;
    logic [PKT_DATA_W-1:0] a;
    logic [PKT_DATA_W-1:0] b;
    logic [PKT_DATA_W-1:0] imm;
    logic [PKT_REG_W-1:0] wr_reg;
    logic reg_write;
  } pkt_t;
  function automatic int pkt_w(input int dw, input int rw);
    return OP_W + FN_W + 3 * dw + rw + 1;
  endfunction
endpackage

// File: rtl/id_ex_skid_reg_slot.sv
// skid_reg_slot: one valid bit plus data register with explicit next-valid and load
module skid_reg_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         nv,
  input  logic [W-1:0] d,
  output logic         v,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      v <= 1'b0;
      q <= '0;
    end else begin
      v <= nv;
      if (ld) q <= d;
    end
  end
endmodule

// File: rtl/id_ex_skid.sv
// id_ex_skid: two-entry skid buffer between decode and execute with flush, halt and bubble counting
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int DATA_W = PKT_DATA_W,
  parameter int REG_W = PKT_REG_W,
  parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opCode,
  input  logic [FN_W-1:0]   in_funct,
  input  logic [DATA_W-1:0] in_A,
  input  logic [DATA_W-1:0] in_B,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_W-1:0]  in_wrReg,
  input  logic              in_regWrite,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_opCode,
  output logic [FN_W-1:0]   out_funct,
  output logic [DATA_W-1:0] out_A,
  output logic [DATA_W-1:0] out_B,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_wrReg,
  output logic              out_regWrite,
  output logic              halted,
  output logic [15:0]       bubble_cnt
);
  localparam int PW = pkt_w(DATA_W, REG_W);
  logic [PW-1:0] in_pkt, m_q, m_d, s_q;
  logic accept, emit, m_nv, m_ld, s_v, s_nv, s_ld, halt_nx;
  assign in_pkt = {in_opCode, in_funct, in_A, in_B, in_imm, in_wrReg, in_regWrite};
  assign {out_opCode, out_funct, out_A, out_B, out_imm, out_wrReg, out_regWrite} = m_q;
  always_comb begin
    accept = in_valid & in_ready;
    emit = out_valid & out_ready;
    m_nv = !flush & (s_v | accept | (out_valid & !emit));
    m_ld = !flush & (s_v ? emit : accept & (!out_valid | emit));
    m_d = s_v ? s_q : in_pkt;
    s_nv = !flush & (s_v ? !emit : accept & out_valid & !emit);
    s_ld = !flush & !s_v & accept & out_valid & !emit;
    halt_nx = !flush & (halted | (accept & (in_opCode == HALT_OP)));
  end
  skid_reg_slot #(.W(PW)) u_main (
    .clk(clk), .rst(rst), .ld(m_ld), .nv(m_nv), .d(m_d), .v(out_valid), .q(m_q)
  );
  skid_reg_slot #(.W(PW)) u_skid (
    .clk(clk), .rst(rst), .ld(s_ld), .nv(s_nv), .d(in_pkt), .v(s_v), .q(s_q)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      halted <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      halted <= halt_nx;
      in_ready <= !s_nv & !halt_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) bubble_cnt <= '0;
    else if (!out_valid && !halted && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
  end
endmodule
